// File: rtl/pipe_pkg.sv
// Shared types for the miniRV pipeline control: datapath widths, the hazard
// scoreboard entry and the load-use sequencer states.
package pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    // One pipeline stage as seen by the hazard logic.
    typedef struct packed {
        logic [RA_W-1:0] wR;
        logic            we;
        logic            load;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam sb_entry_t SB_BUBBLE = '{wR: '0, we: 1'b0, load: 1'b0};

    // A stage supplies a source operand when it writes that non-x0 register.
    function automatic logic sb_hit(input sb_entry_t e, input logic [RA_W-1:0] rs);
        return e.we && (rs != '0) && (e.wR == rs);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority forwarding match for one ID source register against the EX, MEM
// and WB scoreboard entries; the youngest writer wins.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int unsigned DW = XLEN
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic            i_used,
    input  sb_entry_t       i_ex,
    input  sb_entry_t       i_mem,
    input  sb_entry_t       i_wb,
    input  logic [DW-1:0]   i_wd_ex,
    input  logic [DW-1:0]   i_wd_mem,
    input  logic [DW-1:0]   i_wd_wb,
    output logic            o_fwd_en_c,
    output logic [DW-1:0]   o_fwd_val_c,
    output logic            o_load_use_c
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_ex  = i_used && sb_hit(i_ex,  i_rs);
    assign w_hit_mem = i_used && sb_hit(i_mem, i_rs);
    assign w_hit_wb  = i_used && sb_hit(i_wb,  i_rs);

    // A load still in EX has no data yet; that case is reported, not forwarded.
    always_comb begin
        o_fwd_en_c   = 1'b0;
        o_fwd_val_c  = '0;
        o_load_use_c = 1'b0;
        if (w_hit_ex) begin
            if (i_ex.load) begin
                o_load_use_c = 1'b1;
            end else begin
                o_fwd_en_c  = 1'b1;
                o_fwd_val_c = i_wd_ex;
            end
        end else if (w_hit_mem) begin
            o_fwd_en_c  = 1'b1;
            o_fwd_val_c = i_wd_mem;
        end else if (w_hit_wb) begin
            o_fwd_en_c  = 1'b1;
            o_fwd_val_c = i_wd_wb;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage miniRV core: operand forwarding, one-cycle
// load-use stall sequencing, taken-branch flush and stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             inst_valid_ID,
    input  logic [RA_W-1:0]  rs1_ID,
    input  logic [RA_W-1:0]  rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [RA_W-1:0]  wR_ID,
    input  logic             rf_we_ID,
    input  logic             is_load_ID,
    input  logic             br_taken_EX,
    input  logic [XLEN-1:0]  wD_EX,
    input  logic [XLEN-1:0]  wD_MEM,
    input  logic [XLEN-1:0]  wD_WB,
    output logic             forward_en_rD1,
    output logic             forward_en_rD2,
    output logic [XLEN-1:0]  forward_rD1,
    output logic [XLEN-1:0]  forward_rD2,
    output logic             nop,
    output logic             stall_pc,
    output logic             stall_IF_ID,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipe_pkg::*;

    state_e          r_state;
    sb_entry_t       r_sb_ex;
    sb_entry_t       r_sb_mem;
    sb_entry_t       r_sb_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic            w_fe1;
    logic            w_fe2;
    logic [XLEN-1:0] w_fv1;
    logic [XLEN-1:0] w_fv2;
    logic            w_lu1;
    logic            w_lu2;
    logic            w_hazard;
    logic            w_flush;
    logic            w_stall;
    logic            w_nop;
    sb_entry_t       w_sb_id;

    fwd_sel #(.DW(XLEN)) u_fwd_rs1 (
        .i_rs         (rs1_ID),
        .i_used       (rs1_used_ID),
        .i_ex         (r_sb_ex),
        .i_mem        (r_sb_mem),
        .i_wb         (r_sb_wb),
        .i_wd_ex      (wD_EX),
        .i_wd_mem     (wD_MEM),
        .i_wd_wb      (wD_WB),
        .o_fwd_en_c   (w_fe1),
        .o_fwd_val_c  (w_fv1),
        .o_load_use_c (w_lu1)
    );

    fwd_sel #(.DW(XLEN)) u_fwd_rs2 (
        .i_rs         (rs2_ID),
        .i_used       (rs2_used_ID),
        .i_ex         (r_sb_ex),
        .i_mem        (r_sb_mem),
        .i_wb         (r_sb_wb),
        .i_wd_ex      (wD_EX),
        .i_wd_mem     (wD_MEM),
        .i_wd_wb      (wD_WB),
        .o_fwd_en_c   (w_fe2),
        .o_fwd_val_c  (w_fv2),
        .o_load_use_c (w_lu2)
    );

    // A taken branch squashes the ID instruction, so it overrides any stall.
    always_comb begin
        w_hazard = (w_lu1 || w_lu2) && (r_state == RUN);
        w_flush  = br_taken_EX;
        w_stall  = w_hazard && !w_flush;
        w_nop    = w_flush || w_stall;
        w_sb_id  = '{wR: wR_ID, we: rf_we_ID && inst_valid_ID, load: is_load_ID};
    end

    // Outputs feed the same-cycle pipeline controls; reset forces them low at once.
    assign nop            = cpu_rst_n && w_nop;
    assign stall_pc       = cpu_rst_n && w_stall;
    assign stall_IF_ID    = cpu_rst_n && w_stall;
    assign flush_IF_ID    = cpu_rst_n && w_flush;
    assign forward_en_rD1 = cpu_rst_n && w_fe1;
    assign forward_en_rD2 = cpu_rst_n && w_fe2;
    assign forward_rD1    = cpu_rst_n ? w_fv1 : '0;
    assign forward_rD2    = cpu_rst_n ? w_fv2 : '0;
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;

    // Scoreboard always advances; a bubble enters EX whenever ID/EX is nopped.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_sb_ex  <= SB_BUBBLE;
            r_sb_mem <= SB_BUBBLE;
            r_sb_wb  <= SB_BUBBLE;
        end else begin
            r_sb_ex  <= w_nop ? SB_BUBBLE : w_sb_id;
            r_sb_mem <= r_sb_ex;
            r_sb_wb  <= r_sb_mem;
        end
    end

    // Load-use sequencer and event counters.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                RUN:     r_state <= w_stall ? STALL : RUN;
                STALL:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage miniRV core. It produces the forward_en_rD1/rD2, forward_rD1/rD2 and nop controls that the ID/EX pipeline register consumes, plus the PC and IF/ID stall and flush controls. An internal scoreboard mirrors the destination register, write enable and load flag of the EX, MEM and WB stages. Load-use stalls are sequenced by a small FSM, and stall and flush events are counted for the trace and debug bench.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
CNT_W, 32, width of the event counters

Ports:
cpu_clk  in  1  core clock
cpu_rst_n  in  1  asynchronous active-low reset
inst_valid_ID  in  1  the ID slot holds a real instruction
rs1_ID  in  RA_W  ID source register 1
rs2_ID  in  RA_W  ID source register 2
rs1_used_ID  in  1  the ID instruction reads rs1
rs2_used_ID  in  1  the ID instruction reads rs2
wR_ID  in  RA_W  ID destination register
rf_we_ID  in  1  ID register-file write enable
is_load_ID  in  1  the ID instruction is a load
br_taken_EX  in  1  branch or jump resolved taken in EX
wD_EX  in  XLEN  EX result (ALU output or pc4)
wD_MEM  in  XLEN  MEM writeback value, including load data
wD_WB  in  XLEN  WB writeback value
forward_en_rD1  out  1  ID/EX selects forward_rD1
forward_en_rD2  out  1  ID/EX selects forward_rD2
forward_rD1  out  XLEN  forwarded rs1 value
forward_rD2  out  XLEN  forwarded rs2 value
nop  out  1  insert a bubble into ID/EX
stall_pc  out  1  hold the PC
stall_IF_ID  out  1  hold IF/ID
flush_IF_ID  out  1  clear IF/ID to a bubble
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (async, cpu_rst_n=0):
  - scoreboard EX/MEM/WB entries cleared: wR=0, we=0, load=0
  - FSM in RUN; both counters 0
  - all single-bit outputs 0; forward_rD1/rD2 = 0
- Scoreboard, updated on each posedge:
  - EX entry <= {wR_ID, rf_we_ID & inst_valid_ID, is_load_ID}, or a bubble entry when nop=1
  - MEM entry <= EX entry; WB entry <= MEM entry
  - Never stalls; it always advances, mirroring the real pipeline.
- Forwarding (combinational on the current scoreboard and ID inputs, shown for rs1; rs2 identical):
  - A stage matches when rs1_used_ID=1, rs1_ID!=0, stage we=1 and stage wR=rs1_ID.
  - Priority is EX > MEM > WB (youngest wins).
  - EX match with EX load=0: forward_rD1 = wD_EX.
  - EX match with EX load=1: no forward; this raises a load-use hazard.
  - Otherwise MEM match: wD_MEM. Otherwise WB match: wD_WB.
  - forward_en_rD1 = 1 for any forwarded value; with no match, forward_en=0 and forward_rD1=0.
  - x0 is never forwarded.
- Load-use FSM, states RUN and STALL:
  - In RUN, when a hazard is present and br_taken_EX=0: assert nop, stall_pc and stall_IF_ID for that cycle; go to STALL; stall_cnt+1.
  - In STALL: no new stall may be raised. The load now sits in MEM and is forwarded from wD_MEM. Return to RUN unconditionally after one cycle.
  - Maximum stall length is 1 cycle.
- Control hazard:
  - br_taken_EX=1 → nop=1 and flush_IF_ID=1 in the same cycle, stall outputs 0; flush_cnt+1.
  - Branch beats a simultaneous load-use hazard: no stall, no stall_cnt increment, FSM stays or returns to RUN.
  - br_taken_EX=1 while in STALL → flush, then FSM to RUN.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-stall: FSM returns to RUN and all outputs drop asynchronously.

Decomposition:
- Shared package pipe_pkg:
  - XLEN, RA_W
  - scoreboard entry struct {wR, we, load}
  - FSM state enum {RUN, STALL}
- One natural sub-module, fwd_sel: combinational priority match for a single source register, instantiated twice.

Test Plan:
- ADD x5 in EX, ID reads rs1=x5, wD_EX=0x1234 → forward_en_rD1=1, forward_rD1=0x1234, nop=0.
- x5 written in both MEM (0xAA) and WB (0xBB), ID reads rs2=x5 → forward_rD2=0xAA.
- LW x7 in EX, ID reads x7 → one cycle of nop=stall_pc=stall_IF_ID=1 and stall_cnt=1. Next cycle wD_MEM=0xCAFE → forward_rD1=0xCAFE, stall outputs 0.
- LW x7 in EX, ID reads x7, br_taken_EX=1 in the same cycle → nop=1, flush_IF_ID=1, stall_pc=0, stall_cnt=0, flush_cnt=1.
- Writer with wR=0 and we=1 in EX, ID reads x0 → forward_en_rD1=0.
- Pull cpu_rst_n low while in STALL → all outputs 0 immediately, counters 0, and no hazard flagged after release.
